// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the fetch-stage control and address signals of pc_sequencer.
// Clock and reset stay as plain ports on the sequencer itself.
//
// Optional feature macro: PC_REDIRECT_CNT_EN adds redirect_count_o.
//
// Signals (direction as seen by the sequencer, i.e. the slave modport):
//   stall_i          in   hazard unit load-use stall request
//   branch_taken_i   in   EX stage branch resolved taken
//   branch_target_i  in   EX stage branch target
//   jump_valid_i     in   ID stage unconditional jump decoded
//   jump_target_i    in   ID stage jump target
//   halt_i           in   halt instruction retired, stop fetching
//   next_pc_i        in   external next-address mux output fed back
//   pc_o             out  current fetch address
//   seq_addr_o       out  pc_o + 1, sequential mux input
//   redirect_addr_o  out  redirect target, mux jump input
//   redirect_sel_o   out  mux select, 1 = take redirect_addr_o
//   fetch_valid_o    out  instruction at pc_o is to be issued
//   flush_if_id_o    out  kill IF/ID register contents
//   flush_id_ex_o    out  kill ID/EX register contents
//   redirect_count_o out  saturating count of taken redirects (macro only)
// ---------------------------------------------------------------------------
interface pc_sequencer_if;
   logic       stall_i;
   logic       branch_taken_i;
   logic [7:0] branch_target_i;
   logic       jump_valid_i;
   logic [7:0] jump_target_i;
   logic       halt_i;
   logic [7:0] next_pc_i;
   logic [7:0] pc_o;
   logic [7:0] seq_addr_o;
   logic [7:0] redirect_addr_o;
   logic       redirect_sel_o;
   logic       fetch_valid_o;
   logic       flush_if_id_o;
   logic       flush_id_ex_o;
`ifdef PC_REDIRECT_CNT_EN
   logic [15:0] redirect_count_o;
`endif

   // Pipeline side: hazard/branch logic and the next-address mux.
   modport master (
      output stall_i,
      output branch_taken_i,
      output branch_target_i,
      output jump_valid_i,
      output jump_target_i,
      output halt_i,
      output next_pc_i,
      input  pc_o,
      input  seq_addr_o,
      input  redirect_addr_o,
      input  redirect_sel_o,
      input  fetch_valid_o,
      input  flush_if_id_o,
      input  flush_id_ex_o
`ifdef PC_REDIRECT_CNT_EN
      , input redirect_count_o
`endif
   );

   // Sequencer side.
   modport slave (
      input  stall_i,
      input  branch_taken_i,
      input  branch_target_i,
      input  jump_valid_i,
      input  jump_target_i,
      input  halt_i,
      input  next_pc_i,
      output pc_o,
      output seq_addr_o,
      output redirect_addr_o,
      output redirect_sel_o,
      output fetch_valid_o,
      output flush_if_id_o,
      output flush_id_ex_o
`ifdef PC_REDIRECT_CNT_EN
      , output redirect_count_o
`endif
   );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter controller for the pipelined MIPS fetch stage. Holds the
// 8-bit PC, drives the next-address mux select, arbitrates EX branches,
// ID jumps, halts and load-use stalls, and issues pipeline flush pulses.
//
// Optional feature macro: PC_REDIRECT_CNT_EN enables redirect_count_o, a
// 16-bit saturating count of taken redirects, cleared only by reset.
//
// Ports:
//   clk    in   system clock, all state on rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    pc_sequencer_if.slave, control inputs and address/flush outputs
//
// Parameter:
//   RESET_PC  PC value loaded on reset
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] pc;
   logic       active;
   logic       redirect;
   logic       pc_write;
   logic       redirect_sel;
   logic       fetch_valid;
   logic       flush_if_id;
   logic       flush_id_ex;

   // Redirects and stalls only mean anything while the pipeline is fetching.
   assign active   = (state == RUN) || (state == STALL);
   assign redirect = active & (bus.branch_taken_i | bus.jump_valid_i);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A redirect beats halt, which beats stall.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            next_state = RUN;
         end
         RUN, STALL: begin
            if (redirect) begin
               next_state = RUN;
            end else if (bus.halt_i) begin
               next_state = HALT;
            end else if (bus.stall_i) begin
               next_state = STALL;
            end else begin
               next_state = RUN;
            end
         end
         HALT: begin
            next_state = HALT;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output logic. A branch kills both younger stages, a jump only the one
   // behind it in ID. The PC loads on any redirect, or on a plain sequential
   // step when neither halt nor stall holds it.
   always_comb begin
      redirect_sel = 1'b0;
      fetch_valid  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      pc_write     = 1'b0;
      if (active) begin
         fetch_valid  = 1'b1;
         redirect_sel = redirect;
         flush_if_id  = redirect;
         flush_id_ex  = bus.branch_taken_i;
         pc_write     = redirect | (~bus.halt_i & ~bus.stall_i);
      end
   end

   // PC register, loaded from the external mux so the mux remains the only
   // path for the next address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (pc_write) begin
         pc <= bus.next_pc_i;
      end
   end

`ifdef PC_REDIRECT_CNT_EN
   logic [15:0] redirect_count;

   // Saturating redirect counter; it sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_count <= 16'h0000;
      end else if (redirect && (redirect_count != 16'hFFFF)) begin
         redirect_count <= redirect_count + 16'd1;
      end
   end

   assign bus.redirect_count_o = redirect_count;
`endif

   assign bus.pc_o            = pc;
   assign bus.seq_addr_o      = pc + 8'd1;
   assign bus.redirect_addr_o = bus.branch_taken_i ? bus.branch_target_i
                                                   : bus.jump_target_i;
   assign bus.redirect_sel_o  = redirect_sel;
   assign bus.fetch_valid_o   = fetch_valid;
   assign bus.flush_if_id_o   = flush_if_id;
   assign bus.flush_id_ex_o   = flush_id_ex;

endmodule
